// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port round-robin arbiter: requester ID type and
// a clog2 helper that never returns a zero width.
package mem_arb_pkg;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MAX_NB_REQ = 8;
  localparam int REQ_ID_W   = id_width(MAX_NB_REQ);

  typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding transactions; head is the owner of
// the next response. Push when full and pop when empty are ignored.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = REQ_ID_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = id_width(DEPTH);
  localparam int CNT_W = id_width(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // NOTE: storage has no reset; entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_rr_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between NB_REQ requesters;
// an ID FIFO routes in-order responses back to the requester that issued them.
module mem_port_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NB_REQ          = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NB_REQ-1:0]                      req_i,
  input  logic [NB_REQ-1:0]                      we_i,
  input  logic [NB_REQ-1:0][DATA_WIDTH/8-1:0]    be_i,
  input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]      addr_i,
  input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]      wdata_i,
  output logic [NB_REQ-1:0]                      gnt_o,
  output logic [NB_REQ-1:0]                      rvalid_o,
  output logic [DATA_WIDTH-1:0]                  rdata_o,
  output logic                                   mem_req_o,
  output logic                                   mem_we_o,
  output logic [DATA_WIDTH/8-1:0]                mem_be_o,
  output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
  output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
  input  logic                                   mem_gnt_i,
  input  logic                                   mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,
  output logic                                   err_o
);

  req_id_t           rr_ptr;
  req_id_t           sel;
  req_id_t           head;
  logic [NB_REQ-1:0] hi_mask;
  logic [NB_REQ-1:0] masked_req;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              pop;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    hi_mask = '0;
    sel     = '0;
    for (int i = 0; i < NB_REQ; i++) hi_mask[i] = (req_id_t'(i) >= rr_ptr);
    masked_req = req_i & hi_mask;
    for (int i = NB_REQ - 1; i >= 0; i--) if (req_i[i]) sel = req_id_t'(i);
    for (int i = NB_REQ - 1; i >= 0; i--) if (masked_req[i]) sel = req_id_t'(i);
  end

  // Full is taken from the registered count, so a same-cycle response never reopens the port.
  assign mem_req_o = (|req_i) && !fifo_full;
  assign accept    = mem_req_o && mem_gnt_i;
  assign pop       = mem_rvalid_i && !fifo_empty;
  assign rdata_o   = mem_rdata_i;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    gnt_o       = '0;
    rvalid_o    = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (sel == req_id_t'(i)) begin
        mem_we_o    = we_i[i];
        mem_be_o    = be_i[i];
        mem_addr_o  = addr_i[i];
        mem_wdata_o = wdata_i[i];
      end
      gnt_o[i]    = accept && (sel == req_id_t'(i));
      rvalid_o[i] = pop && (head == req_id_t'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      err_o  <= 1'b0;
    end else begin
      if (accept) rr_ptr <= (sel == req_id_t'(NB_REQ - 1)) ? '0 : sel + req_id_t'(1);
      if (mem_rvalid_i && fifo_empty) err_o <= 1'b1;
    end
  end

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (REQ_ID_W)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (sel),
    .pop       (mem_rvalid_i),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

endmodule

// File: tb/tb_mem_port_rr_arbiter.sv
// Scoreboard bench for mem_port_rr_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of round-robin arbitration.
module tb_mem_port_rr_arbiter;

  localparam int NB = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NB-1:0]          req_i;
  logic [NB-1:0]          we_i;
  logic [NB-1:0][BW-1:0]  be_i;
  logic [NB-1:0][AW-1:0]  addr_i;
  logic [NB-1:0][DW-1:0]  wdata_i;
  logic [NB-1:0]          gnt_o;
  logic [NB-1:0]          rvalid_o;
  logic [DW-1:0]          rdata_o;
  logic                   mem_req_o;
  logic                   mem_we_o;
  logic [BW-1:0]          mem_be_o;
  logic [AW-1:0]          mem_addr_o;
  logic [DW-1:0]          mem_wdata_o;
  logic                   mem_gnt_i;
  logic                   mem_rvalid_i;
  logic [DW-1:0]          mem_rdata_i;
  logic                   err_o;

  mem_port_rr_arbiter #(
    .NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: RR pointer, outstanding count, sticky error.
  int   m_ptr = 0;
  int   m_cnt = 0;
  logic m_err = 1'b0;

  exp_t          sb[$];
  pend_t         pend[$];
  int            gnt_log[$];
  logic [NB-1:0] rv_log[$];
  int            last_due = 0;

  // Stimulus controls.
  logic [NB-1:0] granted = '0;
  logic [NB-1:0] auto_refill = '0;
  logic          rand_mode = 1'b0;
  logic          gnt_rand = 1'b0;
  logic          resp_en = 1'b1;
  int            lat_min = 1;
  int            lat_max = 1;
  logic          use_fixed = 1'b0;
  logic [31:0]   fixed_data = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NB-1:0] r, input int p);
    for (int k = 0; k < NB; k++) begin
      int idx;
      idx = (p + k) % NB;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Model check: arbitration, grant pass-through, payload mux, full blocking, error flag.
  always @(negedge clk) begin
    if (rst_n) begin
      logic          exp_req;
      logic          acc;
      logic [NB-1:0] eg;
      int            s;
      exp_t          e;
      pend_t         p;
      exp_req = (|req_i) && (m_cnt < MO);
      s       = rr_pick(req_i, m_ptr);
      acc     = exp_req && mem_gnt_i;
      eg      = '0;
      if (acc) eg[s] = 1'b1;
      check("mem_req_o", 64'(mem_req_o), 64'(exp_req));
      check("gnt_o", 64'(gnt_o), 64'(eg));
      check("err_o", 64'(err_o), 64'(m_err));
      if (exp_req) begin
        check("mem_addr_o", 64'(mem_addr_o), 64'(addr_i[s]));
        check("mem_we_o", 64'(mem_we_o), 64'(we_i[s]));
        check("mem_be_o", 64'(mem_be_o), 64'(be_i[s]));
        check("mem_wdata_o", 64'(mem_wdata_o), 64'(wdata_i[s]));
      end
      if (mem_rvalid_i) begin
        if (m_cnt == 0) m_err = 1'b1;
        else m_cnt--;
      end
      if (acc) begin
        e.id   = s;
        e.data = use_fixed ? fixed_data : $urandom;
        sb.push_back(e);
        p.data = e.data;
        p.due  = cyc + $urandom_range(lat_min, lat_max);
        if (p.due < last_due) p.due = last_due;
        last_due = p.due;
        pend.push_back(p);
        gnt_log.push_back(s);
        m_ptr = (s + 1) % NB;
        m_cnt++;
      end
      granted = gnt_o;
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT routes a response.
  always @(negedge clk) begin
    if (rst_n && rvalid_o != '0) begin
      rv_log.push_back(rvalid_o);
      if (sb.size() == 0) begin
        check("rvalid_unexpected", 64'(rvalid_o), 64'(0));
      end else begin
        exp_t          e;
        logic [NB-1:0] oh;
        e  = sb.pop_front();
        oh = '0;
        oh[e.id] = 1'b1;
        check("rvalid_o", 64'(rvalid_o), 64'(oh));
        check("rdata_o", 64'(rdata_o), 64'(e.data));
      end
    end
  end

  task automatic new_req(input int i);
    req_i[i]   = 1'b1;
    we_i[i]    = 1'($urandom_range(0, 1));
    be_i[i]    = BW'($urandom);
    addr_i[i]  = $urandom;
    wdata_i[i] = $urandom;
  endtask

  // Called just after a rising edge: requester handshake, grant source, downstream responses.
  task automatic drive_cycle();
    for (int i = 0; i < NB; i++) begin
      if (granted[i]) begin
        req_i[i] = 1'b0;
        if (auto_refill[i] || (rand_mode && $urandom_range(0, 1) == 0)) new_req(i);
      end else if (rand_mode && !req_i[i] && $urandom_range(0, 3) == 0) begin
        new_req(i);
      end
    end
    granted = '0;
    if (gnt_rand) mem_gnt_i = ($urandom_range(0, 9) < 7);
    mem_rvalid_i = resp_en && (pend.size() > 0) && (pend[0].due <= cyc);
    if (mem_rvalid_i) mem_rdata_i = pend.pop_front().data;
    else              mem_rdata_i = $urandom;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive_cycle();
    end
  endtask

  task automatic apply_reset();
    rst_n        = 1'b0;
    req_i        = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    auto_refill  = '0;
    granted      = '0;
    sb.delete();
    m_ptr = 0;
    m_cnt = 0;
    m_err = 1'b0;
    #1;
    check("reset_gnt_o", 64'(gnt_o), 64'(0));
    check("reset_rvalid_o", 64'(rvalid_o), 64'(0));
    check("reset_mem_req_o", 64'(mem_req_o), 64'(0));
    check("reset_err_o", 64'(err_o), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    resp_en   = 1'b1;
    gnt_rand  = 1'b0;
    mem_gnt_i = 1'b1;
    while (!(req_i == '0 && pend.size() == 0 && sb.size() == 0) && n < 500) begin
      run(1);
      n++;
    end
    check("drain_timeout", 64'(n >= 500), 64'(0));
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_i = '0; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    #1;
    apply_reset();

    // Single read from requester 1, one-cycle downstream latency.
    req_i = 3'b010; addr_i[1] = 32'h100; we_i[1] = 1'b0; be_i[1] = 4'hF;
    mem_gnt_i = 1'b1; lat_min = 1; lat_max = 1; use_fixed = 1'b1; fixed_data = 32'hCAFE;
    @(negedge clk); #1;
    check("t1_gnt_o", 64'(gnt_o), 64'(3'b010));
    @(posedge clk); #1; drive_cycle();
    @(negedge clk); #1;
    check("t1_rvalid_o", 64'(rvalid_o), 64'(3'b010));
    check("t1_rdata_o", 64'(rdata_o), 64'(32'hCAFE));
    use_fixed = 1'b0;
    drain();

    // Fairness with all requesters continuously asking.
    apply_reset();
    gnt_log.delete();
    for (int i = 0; i < NB; i++) new_req(i);
    auto_refill = 3'b111; mem_gnt_i = 1'b1;
    run(6);
    check("t2_grant_count", 64'(gnt_log.size()), 64'(6));
    for (int k = 0; k < 6 && k < gnt_log.size(); k++)
      check("t2_grant_order", 64'(gnt_log[k]), 64'(k % NB));
    auto_refill = '0;
    drain();

    // Downstream stall for four cycles, grant on the fifth.
    apply_reset();
    new_req(0); mem_gnt_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("t3_stall_gnt_o", 64'(gnt_o), 64'(0));
      check("t3_stall_mem_req_o", 64'(mem_req_o), 64'(1));
      @(posedge clk); #1; drive_cycle();
    end
    mem_gnt_i = 1'b1;
    @(negedge clk); #1;
    check("t3_grant_cycle5", 64'(gnt_o), 64'(3'b001));
    drain();

    // Outstanding limit: two accepts without responses, then release one.
    resp_en = 1'b0; new_req(0); new_req(1); auto_refill = 3'b011; mem_gnt_i = 1'b1;
    run(2);
    @(negedge clk); #1;
    check("t4_full_mem_req_o", 64'(mem_req_o), 64'(0));
    resp_en = 1'b1;
    run(1);
    @(negedge clk); #1;
    check("t4_full_pop_same_cycle", 64'(mem_req_o), 64'(0));
    run(1);
    @(negedge clk); #1;
    check("t4_req_after_pop", 64'(mem_req_o), 64'(1));
    auto_refill = '0;
    drain();

    // Interleaved owners: requester 2 then 0, responses back to back.
    apply_reset();
    rv_log.delete();
    resp_en = 1'b0; mem_gnt_i = 1'b1;
    new_req(2);
    run(1);
    new_req(0);
    run(1);
    drain();
    check("t5_rv_count", 64'(rv_log.size()), 64'(2));
    if (rv_log.size() >= 2) begin
      check("t5_first_rvalid", 64'(rv_log[0]), 64'(3'b100));
      check("t5_second_rvalid", 64'(rv_log[1]), 64'(3'b001));
    end

    // Randomized traffic with random grants and latencies.
    rand_mode = 1'b1; gnt_rand = 1'b1; lat_min = 1; lat_max = 4;
    run(2000);
    rand_mode = 1'b0; lat_min = 1; lat_max = 1;
    drain();

    // Spurious response with nothing outstanding; then asynchronous clear.
    mem_rvalid_i = 1'b1;
    run(3);
    @(negedge clk); #1;
    check("t6_err_sticky", 64'(err_o), 64'(1));
    @(posedge clk); #1;
    apply_reset();

    // Response arriving after reset dropped its entry.
    resp_en = 1'b0; new_req(0); mem_gnt_i = 1'b1;
    run(1);
    apply_reset();
    resp_en = 1'b1;
    run(3);
    @(negedge clk); #1;
    check("t6_late_rvalid_err", 64'(err_o), 64'(1));
    check("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
